// File: rtl/regfile_result_collector.sv
// Captures the word stream from the register-file dump stage into a local buffer,
// tracking a running sum and XOR checksum, with completion, timeout and overflow flags.
module regfile_result_collector #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned SUM_W   = 40,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic [SUM_W-1:0]  sum,
  output logic [DATA_W-1:0] chk,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow
);

  localparam int unsigned IdleW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned CntW  = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

  state_e              state_q;
  logic [IdleW-1:0]    idle_q;
  logic [CntW-1:0]     count_q;
  logic [SUM_W-1:0]    sum_q;
  logic [DATA_W-1:0]   chk_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                busy_q, done_q, timeout_q, overflow_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic capture, last_word, idle_expire, rd_hit;

  always_comb begin
    capture     = (state_q == StCollect) && in_valid && !start;
    last_word   = (count_q == CntW'(DEPTH - 1));
    // TIMEOUT == 0 disables the idle abort entirely.
    idle_expire = (TIMEOUT != 0) && (idle_q == IdleW'(TIMEOUT - 1));
    rd_hit      = ({1'b0, rd_addr} < count_q);
  end

  // Buffer is deliberately not reset; count gates visibility on read-back.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[count_q[ADDR_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idle_q     <= '0;
      count_q    <= '0;
      sum_q      <= '0;
      chk_q      <= '0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_data_q <= rd_hit ? mem[rd_addr] : '0;
      if (start) begin
        state_q    <= StCollect;
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        idle_q     <= '0;
        count_q    <= '0;
        sum_q      <= '0;
        chk_q      <= '0;
        timeout_q  <= 1'b0;
        overflow_q <= 1'b0;
      end else begin
        case (state_q)
          StIdle: ;
          StCollect: begin
            if (in_valid) begin
              count_q <= count_q + CntW'(1);
              sum_q   <= sum_q + SUM_W'(in_data);
              chk_q   <= chk_q ^ in_data;
              idle_q  <= '0;
              if (last_word) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              idle_q <= idle_q + IdleW'(1);
              if (idle_expire) begin
                state_q   <= StDone;
                busy_q    <= 1'b0;
                done_q    <= 1'b1;
                timeout_q <= 1'b1;
              end
            end
          end
          StDone: begin
            if (in_valid) begin
              overflow_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign sum      = sum_q;
  assign chk      = chk_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_regfile_result_collector.sv
// Directed, table-driven bench for regfile_result_collector with hand-computed expectations.
module tb_regfile_result_collector;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_data;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  count;
  logic [39:0] sum;
  logic [31:0] chk;
  logic        busy, done, timeout, overflow;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_result_collector #(
    .DATA_W (32),
    .DEPTH  (16),
    .ADDR_W (4),
    .SUM_W  (40),
    .TIMEOUT(255)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .count   (count),
    .sum     (sum),
    .chk     (chk),
    .busy    (busy),
    .done    (done),
    .timeout (timeout),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  cnt;
    logic [39:0] sum;
    logic [31:0] chk;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".count"}, 64'(count), 64'd0);
    check({tag, ".sum"}, 64'(sum), 64'd0);
    check({tag, ".chk"}, 64'(chk), 64'd0);
    check({tag, ".rd_data"}, 64'(rd_data), 64'd0);
    check({tag, ".flags"}, 64'({busy, done, timeout, overflow}), 64'd0);
  endtask

  initial begin
    // Prefix sums and prefix XORs of 1..n.
    tbl[0]  = '{32'h01, 5'd1,  40'd1,   32'h01};
    tbl[1]  = '{32'h02, 5'd2,  40'd3,   32'h03};
    tbl[2]  = '{32'h03, 5'd3,  40'd6,   32'h00};
    tbl[3]  = '{32'h04, 5'd4,  40'd10,  32'h04};
    tbl[4]  = '{32'h05, 5'd5,  40'd15,  32'h01};
    tbl[5]  = '{32'h06, 5'd6,  40'd21,  32'h07};
    tbl[6]  = '{32'h07, 5'd7,  40'd28,  32'h00};
    tbl[7]  = '{32'h08, 5'd8,  40'd36,  32'h08};
    tbl[8]  = '{32'h09, 5'd9,  40'd45,  32'h01};
    tbl[9]  = '{32'h0A, 5'd10, 40'd55,  32'h0B};
    tbl[10] = '{32'h0B, 5'd11, 40'd66,  32'h00};
    tbl[11] = '{32'h0C, 5'd12, 40'd78,  32'h0C};
    tbl[12] = '{32'h0D, 5'd13, 40'd91,  32'h01};
    tbl[13] = '{32'h0E, 5'd14, 40'd105, 32'h0F};
    tbl[14] = '{32'h0F, 5'd15, 40'd120, 32'h00};
    tbl[15] = '{32'h10, 5'd16, 40'h88,  32'h10};

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    rd_addr  = '0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("post_reset_idle");

    // Run 1: sixteen words 1..16.
    pulse_start();
    check("run1.start_busy", 64'(busy), 64'd1);
    check("run1.start_count", 64'(count), 64'd0);
    for (int i = 0; i < 16; i++) begin
      feed(tbl[i].data);
      check($sformatf("run1.count[%0d]", i), 64'(count), 64'(tbl[i].cnt));
      check($sformatf("run1.sum[%0d]", i), 64'(sum), 64'(tbl[i].sum));
      check($sformatf("run1.chk[%0d]", i), 64'(chk), 64'(tbl[i].chk));
      check($sformatf("run1.done[%0d]", i), 64'(done), (i == 15) ? 64'd1 : 64'd0);
      check($sformatf("run1.busy[%0d]", i), 64'(busy), (i == 15) ? 64'd0 : 64'd1);
    end
    check("run1.timeout", 64'(timeout), 64'd0);

    // Read-back of the full buffer.
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      tick();
      check($sformatf("rdback[%0d]", a), 64'(rd_data), 64'(a + 1));
    end

    // Partial run: reads beyond count return 0, same-cycle write address reads 0.
    pulse_start();
    feed(32'hA);
    feed(32'hB);
    rd_addr = 4'd3;
    tick();
    check("partial.rd3", 64'(rd_data), 64'd0);
    rd_addr = 4'd1;
    tick();
    check("partial.rd1", 64'(rd_data), 64'hB);
    rd_addr = 4'd2;
    feed(32'hC);
    check("partial.rd_same_cycle", 64'(rd_data), 64'd0);
    tick();
    check("partial.rd2", 64'(rd_data), 64'hC);

    // Timeout run: three all-ones words separated by 4 idle cycles, then silence.
    pulse_start();
    for (int w = 0; w < 3; w++) begin
      feed(32'hFFFF_FFFF);
      if (w < 2) repeat (4) tick();
    end
    check("tmo.count", 64'(count), 64'd3);
    repeat (254) tick();
    check("tmo.not_yet_done", 64'(done), 64'd0);
    check("tmo.not_yet_busy", 64'(busy), 64'd1);
    tick();
    check("tmo.done", 64'(done), 64'd1);
    check("tmo.timeout", 64'(timeout), 64'd1);
    check("tmo.busy", 64'(busy), 64'd0);
    check("tmo.count_hold", 64'(count), 64'd3);
    check("tmo.sum", 64'(sum), 64'h2_FFFF_FFFD);
    check("tmo.chk", 64'(chk), 64'hFFFF_FFFF);

    // Overflow in DONE: word dropped, flag sticky until start.
    feed(32'hDEAD);
    check("ovf.set", 64'(overflow), 64'd1);
    check("ovf.sum", 64'(sum), 64'h2_FFFF_FFFD);
    check("ovf.chk", 64'(chk), 64'hFFFF_FFFF);
    check("ovf.count", 64'(count), 64'd3);
    tick();
    check("ovf.sticky", 64'(overflow), 64'd1);
    pulse_start();
    check("ovf.cleared", 64'(overflow), 64'd0);
    check("ovf.timeout_cleared", 64'(timeout), 64'd0);
    check("ovf.busy", 64'(busy), 64'd1);

    // A word on the cycle the timeout would fire is captured instead.
    repeat (254) tick();
    feed(32'h5);
    check("tmo_race.count", 64'(count), 64'd1);
    check("tmo_race.done", 64'(done), 64'd0);
    check("tmo_race.timeout", 64'(timeout), 64'd0);
    check("tmo_race.busy", 64'(busy), 64'd1);

    // Mid-run asynchronous reset after five words.
    for (int i = 0; i < 4; i++) feed(32'(i + 6));
    check("midrst.count5", 64'(count), 64'd5);
    #2 rst = 1'b1;
    #1 check_zero("midrst.async");
    #2 rst = 1'b0;
    rd_addr = 4'd0;
    feed(32'h77);
    check("idle.no_overflow", 64'(overflow), 64'd0);
    check("idle.count", 64'(count), 64'd0);
    check("idle.rd0", 64'(rd_data), 64'd0);

    // Clean run after reset: words 0x100..0x10F.
    pulse_start();
    for (int i = 0; i < 16; i++) feed(32'h100 + 32'(i));
    check("run2.count", 64'(count), 64'd16);
    check("run2.done", 64'(done), 64'd1);
    check("run2.sum", 64'(sum), 64'h1078);
    check("run2.chk", 64'(chk), 64'h0);

    // start coinciding with the 16th word: word ignored, new run begins.
    pulse_start();
    for (int i = 0; i < 15; i++) feed(32'h3);
    check("clash.count15", 64'(count), 64'd15);
    start = 1'b1;
    feed(32'h3);
    start = 1'b0;
    check("clash.busy", 64'(busy), 64'd1);
    check("clash.done", 64'(done), 64'd0);
    check("clash.count", 64'(count), 64'd0);
    check("clash.sum", 64'(sum), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
